maroc_sc_readback: RTL and testbench

MAROC_SC_READBACK -- requirements
Module: maroc_sc_readback

---
 rtl/maroc_sc_pkg.sv | 22 ++
 rtl/sc_edge_det.sv | 24 ++
 rtl/maroc_sc_readback.sv | 138 +++++++++++++
 tb/tb_maroc_sc_readback.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maroc_sc_pkg.sv
// Shared constants, state encoding and helpers for the MAROC slow-control readback checker.
package maroc_sc_pkg;

  localparam int FRAME_LEN = 829;
  localparam int IDX_W     = 10;

  localparam logic [IDX_W-1:0] NO_ERR_IDX = 10'd1023;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CAPTURE,
    ST_DONE
  } sc_state_e;

  // The error count stops at the all-ones code instead of wrapping.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == NO_ERR_IDX) ? v : v + IDX_W'(1);
  endfunction

endpackage

// File: rtl/sc_edge_det.sv
// Brings the slow-control shift clock into the system clock domain and flags each rising edge.
module sc_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ck_sc_i,
  output logic bit_strobe
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ck_sc_i;
      sync2_q <= sync1_q;
    end
  end

  assign bit_strobe = sync1_q & ~sync2_q;

endmodule

// File: rtl/maroc_sc_readback.sv
// Captures the MAROC slow-control chain returned on Q_SC and compares it bit by bit with frame_ref.
// Define SC_READBACK_CAPTURE_EN to also expose the captured frame on rd_frame.
module maroc_sc_readback
  import maroc_sc_pkg::*;
(
  input  logic                 CK_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [FRAME_LEN-1:0] frame_ref,
  input  logic [IDX_W-1:0]     pre_skip,
  input  logic                 CK_SC,
  input  logic                 Q_SC,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [IDX_W-1:0]     err_count,
  output logic [IDX_W-1:0]     first_err_idx
`ifdef SC_READBACK_CAPTURE_EN
  ,
  output logic [FRAME_LEN-1:0] rd_frame
`endif
);

  sc_state_e            state_q;
  logic [FRAME_LEN-1:0] frame_q;
  logic [IDX_W-1:0]     skip_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [IDX_W-1:0]     err_q;
  logic [IDX_W-1:0]     first_err_q;
  logic                 match_q;
  logic                 done_q;

  logic                 bit_strobe;
  logic                 accept;
  logic                 mismatch;
  logic [IDX_W-1:0]     err_d;

  sc_edge_det u_edge (
    .clk_i      (CK_in),
    .rst_i      (rst),
    .ck_sc_i    (CK_SC),
    .bit_strobe (bit_strobe)
  );

  assign accept   = (state_q == ST_IDLE) && start && !abort;
  assign mismatch = Q_SC ^ frame_q[bit_idx_q];
  assign err_d    = mismatch ? sat_inc(err_q) : err_q;

  // Reference is latched once per readback so frame_ref may change during a capture.
  always_ff @(posedge CK_in) begin
    if (accept) begin
      frame_q <= frame_ref;
    end
  end

  always_ff @(posedge CK_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      bit_idx_q   <= '0;
      err_q       <= '0;
      first_err_q <= NO_ERR_IDX;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            skip_q      <= pre_skip;
            bit_idx_q   <= '0;
            err_q       <= '0;
            first_err_q <= NO_ERR_IDX;
            match_q     <= 1'b0;
            state_q     <= (pre_skip == '0) ? ST_CAPTURE : ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (abort) begin
            match_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (bit_strobe) begin
            skip_q <= skip_q - IDX_W'(1);
            if (skip_q == IDX_W'(1)) begin
              state_q <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (abort) begin
            match_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (bit_strobe) begin
            err_q     <= err_d;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            if (mismatch && (first_err_q == NO_ERR_IDX)) begin
              first_err_q <= bit_idx_q;
            end
            // Verdict includes the final bit so match is valid alongside done.
            if (bit_idx_q == LAST_IDX) begin
              match_q <= (err_d == '0);
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SC_READBACK_CAPTURE_EN
  logic [FRAME_LEN-1:0] rd_frame_q;

  always_ff @(posedge CK_in or posedge rst) begin
    if (rst) begin
      rd_frame_q <= '0;
    end else if ((state_q == ST_CAPTURE) && bit_strobe && !abort) begin
      rd_frame_q <= {Q_SC, rd_frame_q[FRAME_LEN-1:1]};
    end
  end

  assign rd_frame = rd_frame_q;
`endif

  assign busy          = (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
  assign done          = done_q;
  assign match         = match_q;
  assign err_count     = err_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_maroc_sc_readback.sv
// Randomized bench for maroc_sc_readback against a stream-level reference model.
module tb_maroc_sc_readback;
  import maroc_sc_pkg::*;

  localparam int N = FRAME_LEN;

  logic         CK_in = 1'b0;
  logic         rst, start, abort, CK_SC, Q_SC;
  logic [N-1:0] frame_ref;
  logic [9:0]   pre_skip;
  logic         busy, done, match;
  logic [9:0]   err_count, first_err_idx;
`ifdef SC_READBACK_CAPTURE_EN
  logic [N-1:0] rd_frame;
`endif

  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  logic match_at_done = 1'b0;
  bit  stream[$];

  always #5 CK_in = ~CK_in;

  maroc_sc_readback dut (
`ifdef SC_READBACK_CAPTURE_EN
    .rd_frame      (rd_frame),
`endif
    .CK_in         (CK_in),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .frame_ref     (frame_ref),
    .pre_skip      (pre_skip),
    .CK_SC         (CK_SC),
    .Q_SC          (Q_SC),
    .busy          (busy),
    .done          (done),
    .match         (match),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  always @(posedge CK_in) begin
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      match_at_done = match;
    end
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  function automatic logic [N-1:0] rand_mask(input int one_in);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, one_in - 1) == 0);
    return m;
  endfunction

  task automatic shift_bit(input bit b);
    stream.push_back(b);
    Q_SC  = b;
    CK_SC = 1'b1;
    repeat (2) @(negedge CK_in);
    CK_SC = 1'b0;
    repeat (2) @(negedge CK_in);
  endtask

  task automatic send_bits(input logic [N-1:0] f, input logic [N-1:0] m, input int from, input int to);
    for (int i = from; i < to; i++) shift_bit(f[i] ^ m[i]);
  endtask

  task automatic do_start(input logic [N-1:0] f, input int pre);
    frame_ref = f;
    pre_skip  = 10'(pre);
    start     = 1'b1;
    @(negedge CK_in);
    start     = 1'b0;
    stream.delete();
  endtask

  // Expected results: the captured word is the stream after the skipped prefix.
  task automatic expect_result(input string tag, input logic [N-1:0] ref_f, input int pre,
                               input int ncap, input bit full);
    int e = 0;
    int f = 1023;
    logic [N-1:0] cap = '0;
    for (int i = 0; i < ncap; i++) begin
      cap[i] = stream[pre + i];
      if (stream[pre + i] != ref_f[i]) begin
        e++;
        if (f == 1023) f = i;
      end
    end
    check({tag, ".err_count"}, err_count, e);
    check({tag, ".first_err_idx"}, first_err_idx, f);
    check({tag, ".match"}, match, (full && e == 0));
    if (full) check({tag, ".match_at_done"}, match_at_done, (e == 0));
`ifdef SC_READBACK_CAPTURE_EN
    if (full) check({tag, ".rd_frame"}, rd_frame, cap);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".match"}, match, 0);
    check({tag, ".err_count"}, err_count, 0);
    check({tag, ".first_err_idx"}, first_err_idx, 1023);
`ifdef SC_READBACK_CAPTURE_EN
    check({tag, ".rd_frame"}, rd_frame, '0);
`endif
  endtask

  initial begin
    logic [N-1:0] f, m, zero;
    int d0, pre;
    bit busy_ok;
    zero = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; CK_SC = 1'b0; Q_SC = 1'b0;
    frame_ref = '0; pre_skip = '0;
    repeat (3) @(negedge CK_in);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge CK_in);

    // Clean loopback, no skip
    f = rand_frame(); d0 = done_cnt;
    do_start(f, 0);
    check("t1.busy_after_start", busy, 1);
    send_bits(f, zero, 0, N);
    repeat (3) @(negedge CK_in);
    check("t1.done_count", done_cnt - d0, 1);
    check("t1.busy_after_done", busy, 0);
    expect_result("t1", f, 0, N, 1);

    // Bits 5 and 700 inverted; frame_ref changes after start
    f = rand_frame(); m = '0; m[5] = 1'b1; m[700] = 1'b1; d0 = done_cnt;
    do_start(f, 0);
    frame_ref = ~f;
    send_bits(f, m, 0, N);
    repeat (3) @(negedge CK_in);
    check("t2.done_count", done_cnt - d0, 1);
    check("t2.err_count_const", err_count, 2);
    check("t2.first_err_const", first_err_idx, 5);
    expect_result("t2", f, 0, N, 1);

    // Full-length skip of an all-ones prefix
    f = rand_frame(); d0 = done_cnt; busy_ok = 1'b1;
    do_start(f, N);
    for (int i = 0; i < N; i++) begin
      shift_bit(1'b1);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("t3.no_done_in_skip", done_cnt - d0, 0);
    for (int i = 0; i < N; i++) begin
      shift_bit(f[i]);
      if (i < N - 1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    repeat (3) @(negedge CK_in);
    check("t3.busy_throughout", busy_ok, 1);
    check("t3.done_count", done_cnt - d0, 1);
    expect_result("t3", f, N, N, 1);

    // Abort at bit 400, then strobes in IDLE, then a clean retry
    f = rand_frame(); m = rand_mask(16); d0 = done_cnt;
    do_start(f, 0);
    send_bits(f, m, 0, 400);
    abort = 1'b1;
    @(negedge CK_in);
    abort = 1'b0;
    check("t4.busy_after_abort", busy, 0);
    expect_result("t4.abort", f, 0, 400, 0);
    send_bits(f, m, 400, 405);
    expect_result("t4.idle_strobes", f, 0, 400, 0);
    check("t4.no_done", done_cnt - d0, 0);
    f = rand_frame();
    do_start(f, 0);
    send_bits(f, zero, 0, N);
    repeat (3) @(negedge CK_in);
    check("t4.retry_done", done_cnt - d0, 1);
    expect_result("t4.retry", f, 0, N, 1);

    // Start during capture is ignored
    f = rand_frame(); m = rand_mask(32); d0 = done_cnt;
    do_start(f, 0);
    send_bits(f, m, 0, 100);
    frame_ref = ~f; pre_skip = 10'd3; start = 1'b1;
    @(negedge CK_in);
    start = 1'b0;
    send_bits(f, m, 100, N);
    repeat (3) @(negedge CK_in);
    check("t5.done_count", done_cnt - d0, 1);
    expect_result("t5", f, 0, N, 1);
    start = 1'b1; abort = 1'b1;
    @(negedge CK_in);
    start = 1'b0; abort = 1'b0;
    @(negedge CK_in);
    check("t5.start_abort_idle", busy, 0);
    send_bits(f, m, 0, 3);
    expect_result("t5.hold", f, 0, N, 1);

    // Reset in mid-capture
    f = rand_frame(); d0 = done_cnt;
    do_start(f, 0);
    send_bits(f, rand_mask(8), 0, 300);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6.async");
    @(negedge CK_in);
    shift_bit(1'b1);
    shift_bit(1'b0);
    rst = 1'b0;
    repeat (2) @(negedge CK_in);
    check_reset_vals("t6.released");
    check("t6.no_done", done_cnt - d0, 0);

    // Random skip lengths and error patterns
    for (int it = 0; it < 4; it++) begin
      f = rand_frame(); m = rand_mask(64); pre = $urandom_range(0, 40); d0 = done_cnt;
      do_start(f, pre);
      for (int i = 0; i < pre; i++) shift_bit(1'($urandom_range(0, 1)));
      send_bits(f, m, 0, N);
      repeat (3) @(negedge CK_in);
      check($sformatf("t7.%0d.done_count", it), done_cnt - d0, 1);
      expect_result($sformatf("t7.%0d", it), f, pre, N, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
